memory_controller: RTL and testbench

- Load/store bus sequencer between the CPU execute stage and external memory.
- On an LDR or STR opcode it latches the address, and for stores the data.
- It then drives the memory address, data and read/write strobes for a configurable number of access cycles.
- For loads it returns the read word to the register file with a one-cycle write-select pulse.

---
 rtl/memory_controller.sv | 194 +++++++++++++++++++
 tb/tb_memory_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/memory_controller.sv
// -----------------------------------------------------------------------------
// memory_controller
//
// Load/store bus sequencer between the CPU execute stage and external memory.
// When it sees an LDR or STR opcode in IDLE it latches the address (and the
// store data), drives the memory bus for WAIT_CYCLES cycles, then signals
// completion. A load also returns the read word to the register file together
// with a one-cycle write-select pulse.
//
// Every output comes straight from a flop, so there is no combinational path
// from an input to an output.
//
// Parameters:
//   LDR_OPCODE   opcode that starts a load
//   STR_OPCODE   opcode that starts a store
//   WAIT_CYCLES  cycles the address stays on the bus before completion (1..15)
//
// Ports:
//   clk               in   system clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   Opcode[3:0]       in   current instruction opcode from decode
//   Address[31:0]     in   effective memory address
//   Data[31:0]        in   store data
//   MemDataIn[31:0]   in   read data returned by memory
//   LDRSel            out  one-cycle destination register write select (loads)
//   AddressBusSel     out  high while the controller owns the address bus
//   RW                out  1 = read, 0 = write
//   LDRDataToDestReg  out  loaded word destined for the register file
//   AddressBus[31:0]  out  address driven to memory
//   DataBus[31:0]     out  write data driven to memory
//   Busy              out  high whenever the controller is not in IDLE
//   Done              out  one-cycle pulse when any access completes
// -----------------------------------------------------------------------------
module memory_controller #(
   parameter logic [3:0]  LDR_OPCODE  = 4'b1101,
   parameter logic [3:0]  STR_OPCODE  = 4'b1100,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  Opcode,
   input  logic [31:0] Address,
   input  logic [31:0] Data,
   input  logic [31:0] MemDataIn,
   output logic        LDRSel,
   output logic        AddressBusSel,
   output logic        RW,
   output logic [31:0] LDRDataToDestReg,
   output logic [31:0] AddressBus,
   output logic [31:0] DataBus,
   output logic        Busy,
   output logic        Done
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   // The counter starts at WAIT_CYCLES-1 and the access finishes on the edge
   // where it is already zero, so the bus is held for exactly WAIT_CYCLES edges.
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        is_load_q, is_load_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ldr_sel_q, ldr_sel_d;
   logic        addr_sel_q, addr_sel_d;
   logic        rw_q, rw_d;
   logic [31:0] ldr_data_q, ldr_data_d;
   logic [31:0] addr_bus_q, addr_bus_d;
   logic [31:0] data_bus_q, data_bus_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   always_comb begin
      // NOTE: every signal gets a hold value first, so no path through the
      // case statement can leave one unassigned and infer a latch.
      state_d    = state_q;
      is_load_d  = is_load_q;
      cnt_d      = cnt_q;
      ldr_sel_d  = ldr_sel_q;
      addr_sel_d = addr_sel_q;
      rw_d       = rw_q;
      ldr_data_d = ldr_data_q;
      addr_bus_d = addr_bus_q;
      data_bus_d = data_bus_q;
      busy_d     = busy_q;
      done_d     = done_q;

      unique case (state_q)
         IDLE: begin
            ldr_sel_d  = 1'b0;
            done_d     = 1'b0;
            addr_sel_d = 1'b0;
            rw_d       = 1'b1;
            addr_bus_d = '0;
            data_bus_d = '0;
            busy_d     = 1'b0;
            cnt_d      = '0;
            if (Opcode == LDR_OPCODE) begin
               state_d    = ACCESS;
               is_load_d  = 1'b1;
               addr_sel_d = 1'b1;
               addr_bus_d = Address;
               rw_d       = 1'b1;
               data_bus_d = '0;
               busy_d     = 1'b1;
               cnt_d      = CNT_INIT;
            end else if (Opcode == STR_OPCODE) begin
               state_d    = ACCESS;
               is_load_d  = 1'b0;
               addr_sel_d = 1'b1;
               addr_bus_d = Address;
               rw_d       = 1'b0;
               data_bus_d = Data;
               busy_d     = 1'b1;
               cnt_d      = CNT_INIT;
            end
         end

         // Bus outputs simply hold; Opcode, Address and Data are not looked at.
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (is_load_q) begin
                  ldr_data_d = MemDataIn;
                  ldr_sel_d  = 1'b1;
               end
               done_d     = 1'b1;
               addr_sel_d = 1'b0;
               addr_bus_d = '0;
               data_bus_d = '0;
               rw_d       = 1'b1;
               state_d    = COMPLETE;
            end
         end

         // One-cycle pulse phase; a held opcode is picked up again from IDLE.
         COMPLETE: begin
            ldr_sel_d = 1'b0;
            done_d    = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state flops use non-blocking assignments so that every flop
      // samples the pre-edge values, regardless of statement order.
      if (!rst_n) begin
         state_q    <= IDLE;
         is_load_q  <= 1'b0;
         cnt_q      <= '0;
         ldr_sel_q  <= 1'b0;
         addr_sel_q <= 1'b0;
         rw_q       <= 1'b1;
         ldr_data_q <= '0;
         addr_bus_q <= '0;
         data_bus_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_load_q  <= is_load_d;
         cnt_q      <= cnt_d;
         ldr_sel_q  <= ldr_sel_d;
         addr_sel_q <= addr_sel_d;
         rw_q       <= rw_d;
         ldr_data_q <= ldr_data_d;
         addr_bus_q <= addr_bus_d;
         data_bus_q <= data_bus_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign LDRSel           = ldr_sel_q;
   assign AddressBusSel    = addr_sel_q;
   assign RW               = rw_q;
   assign LDRDataToDestReg = ldr_data_q;
   assign AddressBus       = addr_bus_q;
   assign DataBus          = data_bus_q;
   assign Busy             = busy_q;
   assign Done             = done_q;

endmodule

// File: tb/tb_memory_controller.sv
// -----------------------------------------------------------------------------
// tb_memory_controller
//
// Directed bench for memory_controller. u_dut1 uses WAIT_CYCLES=1 and u_dut3
// uses WAIT_CYCLES=3. The two instances share the clock, reset, address and
// data inputs, and each has its own opcode input so that they can be driven
// one at a time. Inputs change 1 time unit after a rising edge, and the
// outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_memory_controller;

   localparam logic [3:0] LDR = 4'b1101;
   localparam logic [3:0] STR = 4'b1100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  op1 = 4'h0;
   logic [3:0]  op3 = 4'h0;
   logic [31:0] address = '0;
   logic [31:0] data = '0;
   logic [31:0] mem_data_in = '0;

   logic        ldr_sel1, addr_sel1, rw1, busy1, done1;
   logic [31:0] ldr_data1, addr_bus1, data_bus1;
   logic        ldr_sel3, addr_sel3, rw3, busy3, done3;
   logic [31:0] ldr_data3, addr_bus3, data_bus3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory_controller #(.WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .Opcode(op1), .Address(address), .Data(data),
      .MemDataIn(mem_data_in), .LDRSel(ldr_sel1), .AddressBusSel(addr_sel1),
      .RW(rw1), .LDRDataToDestReg(ldr_data1), .AddressBus(addr_bus1),
      .DataBus(data_bus1), .Busy(busy1), .Done(done1)
   );

   memory_controller #(.WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .Opcode(op3), .Address(address), .Data(data),
      .MemDataIn(mem_data_in), .LDRSel(ldr_sel3), .AddressBusSel(addr_sel3),
      .RW(rw3), .LDRDataToDestReg(ldr_data3), .AddressBus(addr_bus3),
      .DataBus(data_bus3), .Busy(busy3), .Done(done3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks that a controller sits in IDLE with the given held load data.
   task automatic check_idle1(input string tag, input logic [31:0] held);
      check({tag, ".ldrsel"},  32'(ldr_sel1),  32'd0);
      check({tag, ".addrsel"}, 32'(addr_sel1), 32'd0);
      check({tag, ".rw"},      32'(rw1),       32'd1);
      check({tag, ".addr"},    addr_bus1,      32'd0);
      check({tag, ".dbus"},    data_bus1,      32'd0);
      check({tag, ".busy"},    32'(busy1),     32'd0);
      check({tag, ".done"},    32'(done1),     32'd0);
      check({tag, ".ldata"},   ldr_data1,      held);
   endtask

   initial begin
      // ---- Asynchronous reset asserted before the first clock edge ----
      #2 rst_n = 1'b0;
      #1;
      check_idle1("rst_async", 32'd0);
      check("rst_async.busy3", 32'(busy3), 32'd0);
      check("rst_async.rw3",   32'(rw3),   32'd1);
      step();
      step();
      #3 rst_n = 1'b1;      // release mid-cycle
      step();
      check_idle1("rst_release", 32'd0);

      // ---- Load, WAIT_CYCLES=1 ----
      op1 = LDR; address = 32'h1234_5678; data = 32'h9ABC_DEF0;
      mem_data_in = 32'hCAFE_F00D;
      step();               // edge k
      op1 = 4'h0;
      check("ld1.addrsel", 32'(addr_sel1), 32'd1);
      check("ld1.rw",      32'(rw1),       32'd1);
      check("ld1.addr",    addr_bus1,      32'h1234_5678);
      check("ld1.dbus",    data_bus1,      32'd0);
      check("ld1.busy",    32'(busy1),     32'd1);
      check("ld1.ldrsel",  32'(ldr_sel1),  32'd0);
      check("ld1.done",    32'(done1),     32'd0);
      check("ld1.dut3_idle", 32'(busy3),   32'd0);
      step();               // edge k+1
      check("ld2.ldrsel",  32'(ldr_sel1),  32'd1);
      check("ld2.done",    32'(done1),     32'd1);
      check("ld2.ldata",   ldr_data1,      32'hCAFE_F00D);
      check("ld2.addrsel", 32'(addr_sel1), 32'd0);
      check("ld2.addr",    addr_bus1,      32'd0);
      check("ld2.busy",    32'(busy1),     32'd1);
      step();               // edge k+2
      check_idle1("ld3", 32'hCAFE_F00D);

      // ---- Store, WAIT_CYCLES=1 ----
      op1 = STR; address = 32'h0000_0040; data = 32'hDEAD_BEEF;
      mem_data_in = 32'h1111_1111;
      step();
      op1 = 4'h0;
      check("st1.rw",      32'(rw1),       32'd0);
      check("st1.dbus",    data_bus1,      32'hDEAD_BEEF);
      check("st1.addr",    addr_bus1,      32'h0000_0040);
      check("st1.addrsel", 32'(addr_sel1), 32'd1);
      step();
      check("st2.done",    32'(done1),     32'd1);
      check("st2.ldrsel",  32'(ldr_sel1),  32'd0);
      check("st2.ldata",   ldr_data1,      32'hCAFE_F00D);
      check("st2.rw",      32'(rw1),       32'd1);
      check("st2.dbus",    data_bus1,      32'd0);
      step();
      check_idle1("st3", 32'hCAFE_F00D);

      // ---- Non-memory opcode held for 5 cycles ----
      op1 = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         step();
         check("nop.busy",    32'(busy1),     32'd0);
         check("nop.addrsel", 32'(addr_sel1), 32'd0);
         check("nop.pulse",   32'({ldr_sel1, done1}), 32'd0);
      end
      op1 = 4'h0;

      // ---- WAIT_CYCLES=3 load, inputs changed during ACCESS ----
      op3 = LDR; address = 32'h0000_0200; mem_data_in = 32'hBAD0_0001;
      step();               // edge k
      op3 = 4'h0; address = 32'hFFFF_FFFF; data = 32'h0BAD_0BAD;
      check("w3.k.addrsel", 32'(addr_sel3), 32'd1);
      check("w3.k.addr",    addr_bus3,      32'h0000_0200);
      step();               // edge k+1
      check("w3.k1.addrsel", 32'(addr_sel3), 32'd1);
      check("w3.k1.addr",    addr_bus3,      32'h0000_0200);
      check("w3.k1.pulse",   32'({ldr_sel3, done3}), 32'd0);
      step();               // edge k+2
      check("w3.k2.addrsel", 32'(addr_sel3), 32'd1);
      check("w3.k2.pulse",   32'({ldr_sel3, done3}), 32'd0);
      check("w3.k2.dbus",    data_bus3,      32'd0);
      mem_data_in = 32'h600D_F00D;
      step();               // edge k+3: capture
      check("w3.k3.ldrsel",  32'(ldr_sel3),  32'd1);
      check("w3.k3.done",    32'(done3),     32'd1);
      check("w3.k3.ldata",   ldr_data3,      32'h600D_F00D);
      check("w3.k3.addrsel", 32'(addr_sel3), 32'd0);
      check("w3.k3.dut1",    ldr_data1,      32'hCAFE_F00D);
      step();               // edge k+4
      check("w3.k4.ldrsel",  32'(ldr_sel3),  32'd0);
      check("w3.k4.busy",    32'(busy3),     32'd0);
      check("w3.k4.done",    32'(done3),     32'd0);

      // ---- Held LDR opcode is accepted again straight from IDLE ----
      op1 = LDR; address = 32'h0000_0300; mem_data_in = 32'h0000_0077;
      step();               // accept
      step();               // complete
      check("hold.done",  32'(done1), 32'd1);
      step();               // back to IDLE, opcode not sampled in COMPLETE
      check("hold.idle",  32'(busy1), 32'd0);
      step();               // accepted again
      check("hold.again", 32'(addr_sel1), 32'd1);
      op1 = 4'h0;
      step();
      step();

      // ---- Reset asserted mid-access ----
      op1 = STR; address = 32'h0000_0500; data = 32'h1234_0000;
      step();
      op1 = 4'h0;
      check("rma.addrsel", 32'(addr_sel1), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_idle1("rma", 32'd0);
      step();
      #3 rst_n = 1'b1;
      step();
      check("rma.post_pulse", 32'({ldr_sel1, done1}), 32'd0);
      check("rma.post_busy",  32'(busy1), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
